// File: rtl/alu32_flag_cond.sv
// alu32_flag_cond
//   Architectural c/n/z/v flag register plus a condition-code evaluator that
//   answers branch/select queries through a valid/ready request channel and
//   a held (registered) response.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   f_wr, f_op[2:0]           flag write strobe and ALU op of the result;
//                             f_op[2:1]==2'b11 marks an arithmetic op
//   f_c, f_n, f_z, f_v        flags produced by the ALU
//   q_valid, q_ready, q_cond  condition query channel (4-bit code)
//   r_valid, r_ready, r_taken held response channel
//   c_q, n_q, z_q, v_q        registered flags
//   dbg_state                 response FSM state (0 EMPTY, 1 HELD)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The producer holds its payload stable while valid is high and ready
// is low; the response stays valid with r_taken frozen until r_ready.
//
// Optional feature macro: FLAG_BYPASS_EN
//   defined   - queries never stall; a query coinciding with a flag write
//               evaluates the merged new flags.
//   undefined - a query coinciding with a flag write is held off one cycle
//               and evaluates the updated registered flags.
module alu32_flag_cond (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       f_wr,
  input  logic [2:0] f_op,
  input  logic       f_c,
  input  logic       f_n,
  input  logic       f_z,
  input  logic       f_v,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic [3:0] q_cond,
  output logic       r_valid,
  input  logic       r_ready,
  output logic       r_taken,
  output logic       c_q,
  output logic       n_q,
  output logic       z_q,
  output logic       v_q,
  output logic       dbg_state
);

  typedef enum logic {S_EMPTY = 1'b0, S_HELD = 1'b1} state_t;

  state_t r_state;

  logic w_arith;
  logic w_stall;
  logic w_accept;
  logic w_ec, w_en, w_ez, w_ev;
  logic w_eval;
  logic w_unused_op0;

  // Only the add/sub distinction is encoded in f_op[0]; it does not affect
  // which flags are captured.
  assign w_unused_op0 = f_op[0];
  assign w_arith      = (f_op[2:1] == 2'b11);

`ifdef FLAG_BYPASS_EN
  assign w_stall = 1'b0;
  // Forward the flags that this cycle's write is about to commit.
  assign w_en = f_wr ? f_n : n_q;
  assign w_ez = f_wr ? f_z : z_q;
  assign w_ec = (f_wr && w_arith) ? f_c : c_q;
  assign w_ev = (f_wr && w_arith) ? f_v : v_q;
`else
  // Stalling on f_wr guarantees the registered flags are current at accept.
  assign w_stall = f_wr;
  assign w_en    = n_q;
  assign w_ez    = z_q;
  assign w_ec    = c_q;
  assign w_ev    = v_q;
`endif

  assign r_valid   = (r_state == S_HELD);
  assign dbg_state = r_state;
  assign q_ready   = (!r_valid || r_ready) && !w_stall;
  assign w_accept  = q_valid && q_ready;

  function automatic logic eval_cond(input logic [3:0] cond,
                                     input logic c, input logic n,
                                     input logic z, input logic v);
    logic res;
    res = 1'b0;
    case (cond)
      4'h0: res = z;
      4'h1: res = !z;
      4'h2: res = c;
      4'h3: res = !c;
      4'h4: res = n;
      4'h5: res = !n;
      4'h6: res = v;
      4'h7: res = !v;
      4'h8: res = c && !z;
      4'h9: res = !c || z;
      4'hA: res = (n == v);
      4'hB: res = (n != v);
      4'hC: res = !z && (n == v);
      4'hD: res = z || (n != v);
      4'hE: res = 1'b1;
      4'hF: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_eval = eval_cond(q_cond, w_ec, w_en, w_ez, w_ev);

  // Flag register: logic ops report c=v=0, which must not clobber c/v.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else if (f_wr) begin
      n_q <= f_n;
      z_q <= f_z;
      if (w_arith) begin
        c_q <= f_c;
        v_q <= f_v;
      end
    end
  end

  // Response FSM. In HELD with r_ready low, q_ready is low, so no accept
  // can occur and r_taken stays frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_taken <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state <= S_HELD;
            r_taken <= w_eval;
          end
        end
        S_HELD: begin
          if (r_ready) begin
            if (w_accept) begin
              r_state <= S_HELD;
              r_taken <= w_eval;
            end else begin
              r_state <= S_EMPTY;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_flag_cond.sv
// tb_alu32_flag_cond
//   Directed bench for alu32_flag_cond: a table of {flags, condition,
//   expected result} records applied in a loop, plus hand-written sequences
//   for reset, c/v preservation, backpressure, back-to-back and the
//   write/query hazard.
module tb_alu32_flag_cond;

  logic       clk;
  logic       reset_n;
  logic       f_wr;
  logic [2:0] f_op;
  logic       f_c, f_n, f_z, f_v;
  logic       q_valid;
  logic       q_ready;
  logic [3:0] q_cond;
  logic       r_valid;
  logic       r_ready;
  logic       r_taken;
  logic       c_q, n_q, z_q, v_q;
  logic       dbg_state;

  int n_pass;
  int n_total;

  alu32_flag_cond dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .f_wr      (f_wr),
    .f_op      (f_op),
    .f_c       (f_c),
    .f_n       (f_n),
    .f_z       (f_z),
    .f_v       (f_v),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_cond    (q_cond),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_taken   (r_taken),
    .c_q       (c_q),
    .n_q       (n_q),
    .z_q       (z_q),
    .v_q       (v_q),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {c,n,z,v}
  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [2:0] op, input logic c,
                             input logic n, input logic z, input logic v);
    f_wr = 1'b1; f_op = op;
    f_c = c; f_n = n; f_z = z; f_v = v;
    tick();
    f_wr = 1'b0;
  endtask

  // One isolated query from EMPTY; leaves the FSM EMPTY again.
  task automatic do_query(input string name, input logic [3:0] cond,
                          input logic exp);
    q_valid = 1'b1; q_cond = cond; r_ready = 1'b0;
    #1;
    check({name, "_qready"}, {7'd0, q_ready}, 8'd1);
    tick();
    q_valid = 1'b0;
    check({name, "_rvalid"}, {7'd0, r_valid}, 8'd1);
    check({name, "_taken"}, {7'd0, r_taken}, {7'd0, exp});
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check({name, "_drain"}, {7'd0, r_valid}, 8'd0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0;
    f_wr = 1'b0; f_op = 3'b000;
    f_c = 1'b0; f_n = 1'b0; f_z = 1'b0; f_v = 1'b0;
    q_valid = 1'b0; q_cond = 4'h0; r_ready = 1'b0;

    vecs[0]  = '{4'b0010, 4'h0, 1'b1};  // EQ z
    vecs[1]  = '{4'b0000, 4'h0, 1'b0};
    vecs[2]  = '{4'b0010, 4'h1, 1'b0};  // NE
    vecs[3]  = '{4'b0000, 4'h1, 1'b1};
    vecs[4]  = '{4'b1000, 4'h2, 1'b1};  // CS
    vecs[5]  = '{4'b1000, 4'h3, 1'b0};  // CC
    vecs[6]  = '{4'b0100, 4'h4, 1'b1};  // MI
    vecs[7]  = '{4'b0100, 4'h5, 1'b0};  // PL
    vecs[8]  = '{4'b0001, 4'h6, 1'b1};  // VS
    vecs[9]  = '{4'b0001, 4'h7, 1'b0};  // VC
    vecs[10] = '{4'b1000, 4'h8, 1'b1};  // HI c&!z
    vecs[11] = '{4'b1010, 4'h8, 1'b0};
    vecs[12] = '{4'b1010, 4'h9, 1'b1};  // LS !c|z
    vecs[13] = '{4'b1000, 4'h9, 1'b0};
    vecs[14] = '{4'b0100, 4'hA, 1'b0};  // GE, n=1 v=0
    vecs[15] = '{4'b0100, 4'hB, 1'b1};  // LT
    vecs[16] = '{4'b0100, 4'hC, 1'b0};  // GT
    vecs[17] = '{4'b0100, 4'hD, 1'b1};  // LE
    vecs[18] = '{4'b0101, 4'hA, 1'b1};  // GE, n=v=1
    vecs[19] = '{4'b0101, 4'hC, 1'b1};  // GT, z=0
    vecs[20] = '{4'b0010, 4'hC, 1'b0};  // GT blocked by z
    vecs[21] = '{4'b0000, 4'hE, 1'b1};  // AL
    vecs[22] = '{4'b1111, 4'hE, 1'b1};
    vecs[23] = '{4'b1111, 4'hF, 1'b0};  // NV
    vecs[24] = '{4'b0000, 4'hF, 1'b0};

    // reset state
    #2;
    check("rst_rvalid", {7'd0, r_valid}, 8'd0);
    check("rst_taken", {7'd0, r_taken}, 8'd0);
    check("rst_flags", {4'd0, c_q, n_q, z_q, v_q}, 8'd0);
    check("rst_qready", {7'd0, q_ready}, 8'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // table-driven vectors
    for (int i = 0; i < 25; i++) begin
      write_flags(3'b110, vecs[i].flags[3], vecs[i].flags[2],
                  vecs[i].flags[1], vecs[i].flags[0]);
      check($sformatf("vec%0d_flags", i), {4'd0, c_q, n_q, z_q, v_q},
            {4'd0, vecs[i].flags});
      do_query($sformatf("vec%0d", i), vecs[i].cond, vecs[i].exp);
    end

    // logic op preserves c/v
    write_flags(3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
    write_flags(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("logic_keep_cv", {4'd0, c_q, n_q, z_q, v_q}, 8'b0000_1011);
    do_query("logic_hi", 4'h8, 1'b0);
    do_query("logic_cs", 4'h2, 1'b1);

    // backpressure: z_q=1, query EQ, hold 4 cycles while z written to 0
    write_flags(3'b110, 1'b0, 1'b0, 1'b1, 1'b0);
    q_valid = 1'b1; q_cond = 4'h0; r_ready = 1'b0;
    tick();
    check("bp_rvalid0", {7'd0, r_valid}, 8'd1);
    check("bp_taken0", {7'd0, r_taken}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      f_wr = 1'b1; f_op = 3'b000; f_z = 1'b0; f_c = 1'b0; f_v = 1'b0; f_n = 1'b0;
      q_cond = 4'h1;
      #1;
      check($sformatf("bp_qready%0d", i), {7'd0, q_ready}, 8'd0);
      tick();
      check($sformatf("bp_rvalid%0d", i), {7'd0, r_valid}, 8'd1);
      check($sformatf("bp_taken%0d", i), {7'd0, r_taken}, 8'd1);
    end
    f_wr = 1'b0; q_valid = 1'b0;
    check("bp_zq", {7'd0, z_q}, 8'd0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("bp_release", {7'd0, r_valid}, 8'd0);

    // back-to-back EQ, NE, EQ with z_q=1
    write_flags(3'b110, 1'b0, 1'b0, 1'b1, 1'b0);
    r_ready = 1'b1; q_valid = 1'b1; q_cond = 4'h0;
    tick();
    check("b2b_v0", {7'd0, r_valid}, 8'd1);
    check("b2b_t0", {7'd0, r_taken}, 8'd1);
    q_cond = 4'h1;
    #1;
    check("b2b_qready", {7'd0, q_ready}, 8'd1);
    tick();
    check("b2b_v1", {7'd0, r_valid}, 8'd1);
    check("b2b_t1", {7'd0, r_taken}, 8'd0);
    q_cond = 4'h0;
    tick();
    check("b2b_v2", {7'd0, r_valid}, 8'd1);
    check("b2b_t2", {7'd0, r_taken}, 8'd1);
    q_valid = 1'b0;
    tick();
    check("b2b_drain", {7'd0, r_valid}, 8'd0);
    r_ready = 1'b0;

    // hazard: z_q=0, f_wr z=1 in the same cycle as query EQ
    write_flags(3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
    f_wr = 1'b1; f_op = 3'b000; f_z = 1'b1;
    q_valid = 1'b1; q_cond = 4'h0; r_ready = 1'b1;
    #1;
`ifdef FLAG_BYPASS_EN
    check("haz_qready", {7'd0, q_ready}, 8'd1);
    tick();
    f_wr = 1'b0; q_valid = 1'b0;
    check("haz_rvalid", {7'd0, r_valid}, 8'd1);
    check("haz_taken", {7'd0, r_taken}, 8'd1);
`else
    check("haz_qready_stall", {7'd0, q_ready}, 8'd0);
    tick();
    f_wr = 1'b0;
    #1;
    check("haz_qready_go", {7'd0, q_ready}, 8'd1);
    check("haz_rvalid_wait", {7'd0, r_valid}, 8'd0);
    tick();
    q_valid = 1'b0;
    check("haz_rvalid", {7'd0, r_valid}, 8'd1);
    check("haz_taken", {7'd0, r_taken}, 8'd1);
`endif
    tick();
    r_ready = 1'b0;

    // reset mid-HELD: all flags 1, query AL, then async reset between edges
    write_flags(3'b110, 1'b1, 1'b1, 1'b1, 1'b1);
    q_valid = 1'b1; q_cond = 4'hE;
    tick();
    q_valid = 1'b0;
    check("mid_rvalid_pre", {7'd0, r_valid}, 8'd1);
    check("mid_taken_pre", {7'd0, r_taken}, 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rvalid", {7'd0, r_valid}, 8'd0);
    check("mid_taken", {7'd0, r_taken}, 8'd0);
    check("mid_flags", {4'd0, c_q, n_q, z_q, v_q}, 8'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_rvalid", {7'd0, r_valid}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
